// File: rtl/mnist_window_streamer.sv
// mnist_window_streamer: buffers one 28x28 image and streams every 5x5 window with its position
module mnist_window_streamer #(
    parameter int IMG_W = 28,
    parameter int K     = 5,
    parameter int PW    = 8
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              PIX_VALID,
    input  logic [PW-1:0]     PIX_DATA,
    output logic              LOAD_READY,
    output logic              IMG_LOADED,
    input  logic              START,
    output logic              WIN_VALID,
    input  logic              WIN_READY,
    output logic [4:0]        X,
    output logic [4:0]        Y,
    output logic [K*K*PW-1:0] IMGIN,
    output logic              STREAM_DONE
);
    localparam int NPOS = IMG_W - K + 1;
    localparam int NPIX = IMG_W * IMG_W;

    typedef enum logic [1:0] {ST_LOAD, ST_WAIT, ST_STREAM} state_t;

    state_t             state;
    logic [9:0]         wr_ptr;
    logic [PW-1:0]      mem [NPIX];
    logic [4:0]         nx, ny;
    logic [9:0]         base;
    logic [K*K*PW-1:0]  win;
    logic               last_win;

    // Next window position: first window when leaving WAIT, otherwise Y-inner raster advance
    always_comb begin
        last_win = (X == 5'(NPOS-1)) && (Y == 5'(NPOS-1));
        nx = (state != ST_STREAM) ? 5'd0 : (Y == 5'(NPOS-1)) ? X + 5'd1 : X;
        ny = (state != ST_STREAM || Y == 5'(NPOS-1)) ? 5'd0 : Y + 5'd1;
        base = 10'(nx) * 10'(IMG_W) + 10'(ny);
    end

    for (genvar i = 0; i < K; i++) begin : g_r
        for (genvar j = 0; j < K; j++) begin : g_c
            assign win[(i*K+j)*PW +: PW] = mem[base + 10'(i*IMG_W + j)];
        end
    end

    // Pixel buffer: written only while loading, never cleared
    always_ff @(posedge CLK) begin
        if (nRST && state == ST_LOAD && PIX_VALID)
            mem[wr_ptr] <= PIX_DATA;
    end

    // Control FSM with registered handshake and window outputs
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state       <= ST_LOAD;
            wr_ptr      <= '0;
            LOAD_READY  <= 1'b1;
            IMG_LOADED  <= 1'b0;
            WIN_VALID   <= 1'b0;
            X           <= '0;
            Y           <= '0;
            IMGIN       <= '0;
            STREAM_DONE <= 1'b0;
        end else begin
            STREAM_DONE <= 1'b0;
            case (state)
                ST_LOAD: if (PIX_VALID) begin
                    wr_ptr <= wr_ptr + 10'd1;
                    if (wr_ptr == 10'(NPIX-1)) begin
                        state      <= ST_WAIT;
                        wr_ptr     <= '0;
                        LOAD_READY <= 1'b0;
                        IMG_LOADED <= 1'b1;
                    end
                end
                ST_WAIT: if (START) begin
                    state      <= ST_STREAM;
                    IMG_LOADED <= 1'b0;
                    WIN_VALID  <= 1'b1;
                    X          <= nx;
                    Y          <= ny;
                    IMGIN      <= win;
                end
                ST_STREAM: if (WIN_READY) begin
                    if (last_win) begin
                        state       <= ST_LOAD;
                        wr_ptr      <= '0;
                        LOAD_READY  <= 1'b1;
                        WIN_VALID   <= 1'b0;
                        STREAM_DONE <= 1'b1;
                        X           <= '0;
                        Y           <= '0;
                    end else begin
                        X     <= nx;
                        Y     <= ny;
                        IMGIN <= win;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_mnist_window_streamer.sv
// tb_mnist_window_streamer: directed scenarios for the window streamer
module tb_mnist_window_streamer;
    logic         CLK = 1'b0;
    logic         nRST = 1'b0;
    logic         PIX_VALID = 1'b0;
    logic [7:0]   PIX_DATA = '0;
    logic         LOAD_READY, IMG_LOADED, WIN_VALID, STREAM_DONE;
    logic         START = 1'b0;
    logic         WIN_READY = 1'b0;
    logic [4:0]   X, Y;
    logic [199:0] IMGIN;
    logic [7:0]   img [784];
    int           checks = 0;
    int           failures = 0;

    mnist_window_streamer dut (
        .CLK(CLK), .nRST(nRST), .PIX_VALID(PIX_VALID), .PIX_DATA(PIX_DATA),
        .LOAD_READY(LOAD_READY), .IMG_LOADED(IMG_LOADED), .START(START),
        .WIN_VALID(WIN_VALID), .WIN_READY(WIN_READY), .X(X), .Y(Y),
        .IMGIN(IMGIN), .STREAM_DONE(STREAM_DONE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic logic [199:0] exp_win(input int x, input int y);
        logic [199:0] r;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                r[(i*5+j)*8 +: 8] = img[(x+i)*28 + y + j];
        return r;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_img(input int mode);
        for (int k = 0; k < 784; k++) begin
            img[k] = (mode == 0) ? 8'(k) : 8'h80;
            PIX_VALID = 1'b1;
            PIX_DATA = img[k];
            step();
        end
        PIX_VALID = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        step();
        step();
        nRST = 1'b1;
        checks++; if (LOAD_READY !== 1'b1) begin failures++; $display("FAIL rst_load_ready got=%b exp=1", LOAD_READY); end
        checks++; if (IMG_LOADED !== 1'b0) begin failures++; $display("FAIL rst_img_loaded got=%b exp=0", IMG_LOADED); end
        checks++; if (WIN_VALID !== 1'b0) begin failures++; $display("FAIL rst_win_valid got=%b exp=0", WIN_VALID); end
        checks++; if (X !== 5'd0 || Y !== 5'd0) begin failures++; $display("FAIL rst_xy got=%0d,%0d exp=0,0", X, Y); end
        checks++; if (IMGIN !== '0) begin failures++; $display("FAIL rst_imgin got=%h exp=0", IMGIN); end
        checks++; if (STREAM_DONE !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", STREAM_DONE); end
    endtask

    task automatic test_start_ignored();
        for (int k = 0; k < 784; k++) begin
            img[k] = 8'(k);
            PIX_VALID = 1'b1;
            PIX_DATA = img[k];
            START = (k == 500 || k == 783);
            if (k == 783) begin
                checks++; if (IMG_LOADED !== 1'b0) begin failures++; $display("FAIL early_loaded got=%b exp=0", IMG_LOADED); end
            end
            step();
            if (k == 500) begin
                checks++; if (WIN_VALID !== 1'b0) begin failures++; $display("FAIL start_in_load got=%b exp=0", WIN_VALID); end
            end
        end
        PIX_VALID = 1'b0;
        START = 1'b0;
        checks++; if (IMG_LOADED !== 1'b1) begin failures++; $display("FAIL loaded got=%b exp=1", IMG_LOADED); end
        checks++; if (LOAD_READY !== 1'b0) begin failures++; $display("FAIL load_ready_wait got=%b exp=0", LOAD_READY); end
        checks++; if (WIN_VALID !== 1'b0) begin failures++; $display("FAIL start_last_accept got=%b exp=0", WIN_VALID); end
        step();
        checks++; if (WIN_VALID !== 1'b0 || IMG_LOADED !== 1'b1) begin failures++; $display("FAIL wait_hold got=%b/%b exp=0/1", WIN_VALID, IMG_LOADED); end
    endtask

    task automatic test_ramp_stream();
        PIX_VALID = 1'b1;
        PIX_DATA = 8'hFF;
        for (int n = 0; n < 3; n++) begin
            step();
            checks++; if (LOAD_READY !== 1'b0 || IMG_LOADED !== 1'b1) begin failures++; $display("FAIL wait_extra got=%b/%b exp=0/1", LOAD_READY, IMG_LOADED); end
        end
        WIN_READY = 1'b1;
        START = 1'b1;
        step();
        START = 1'b0;
        checks++; if (IMG_LOADED !== 1'b0) begin failures++; $display("FAIL stream_loaded got=%b exp=0", IMG_LOADED); end
        checks++; if (IMGIN[7:0] !== 8'd0 || IMGIN[39:32] !== 8'd4 || IMGIN[47:40] !== 8'd28 || IMGIN[199:192] !== 8'd116)
            begin failures++; $display("FAIL win00_bytes got=%h exp=bytes 0,4,28,116", IMGIN); end
        for (int c = 0; c < 576; c++) begin
            checks++; if (WIN_VALID !== 1'b1 || X !== 5'(c/24) || Y !== 5'(c%24))
                begin failures++; $display("FAIL ramp_pos c=%0d got=%b %0d,%0d exp=1 %0d,%0d", c, WIN_VALID, X, Y, c/24, c%24); end
            checks++; if (IMGIN !== exp_win(c/24, c%24)) begin failures++; $display("FAIL ramp_win c=%0d got=%h exp=%h", c, IMGIN, exp_win(c/24, c%24)); end
            checks++; if (LOAD_READY !== 1'b0 || STREAM_DONE !== 1'b0) begin failures++; $display("FAIL ramp_ctrl c=%0d got=%b/%b exp=0/0", c, LOAD_READY, STREAM_DONE); end
            if (c == 575) begin
                checks++; if (IMGIN[7:0] !== 8'd155 || IMGIN[199:192] !== 8'd15) begin failures++; $display("FAIL win2323_bytes got=%h exp=bytes 155,15", IMGIN); end
            end
            step();
        end
        PIX_VALID = 1'b0;
        checks++; if (STREAM_DONE !== 1'b1 || WIN_VALID !== 1'b0 || LOAD_READY !== 1'b1)
            begin failures++; $display("FAIL done_edge got=%b/%b/%b exp=1/0/1", STREAM_DONE, WIN_VALID, LOAD_READY); end
        checks++; if (X !== 5'd0 || Y !== 5'd0) begin failures++; $display("FAIL done_xy got=%0d,%0d exp=0,0", X, Y); end
        step();
        checks++; if (STREAM_DONE !== 1'b0) begin failures++; $display("FAIL done_pulse got=%b exp=0", STREAM_DONE); end
    endtask

    task automatic test_stall();
        load_img(0);
        WIN_READY = 1'b1;
        START = 1'b1;
        step();
        START = 1'b0;
        for (int n = 0; n < 94; n++) step();
        checks++; if (X !== 5'd3 || Y !== 5'd22) begin failures++; $display("FAIL stall_pos got=%0d,%0d exp=3,22", X, Y); end
        WIN_READY = 1'b0;
        for (int n = 0; n < 7; n++) begin
            step();
            checks++; if (WIN_VALID !== 1'b1 || X !== 5'd3 || Y !== 5'd22 || IMGIN !== exp_win(3, 22))
                begin failures++; $display("FAIL stall_hold n=%0d got=%b %0d,%0d %h", n, WIN_VALID, X, Y, IMGIN); end
        end
        WIN_READY = 1'b1;
        step();
        checks++; if (X !== 5'd3 || Y !== 5'd23 || IMGIN !== exp_win(3, 23)) begin failures++; $display("FAIL release1 got=%0d,%0d exp=3,23", X, Y); end
        step();
        checks++; if (X !== 5'd4 || Y !== 5'd0 || IMGIN !== exp_win(4, 0)) begin failures++; $display("FAIL release2 got=%0d,%0d exp=4,0", X, Y); end
    endtask

    task automatic test_midreset();
        for (int n = 0; n < 149; n++) step();
        checks++; if (X !== 5'd10 || Y !== 5'd5) begin failures++; $display("FAIL pre_reset_pos got=%0d,%0d exp=10,5", X, Y); end
        nRST = 1'b0;
        step();
        nRST = 1'b1;
        checks++; if (WIN_VALID !== 1'b0 || IMG_LOADED !== 1'b0 || LOAD_READY !== 1'b1 || STREAM_DONE !== 1'b0)
            begin failures++; $display("FAIL midreset got=%b/%b/%b/%b exp=0/0/1/0", WIN_VALID, IMG_LOADED, LOAD_READY, STREAM_DONE); end
        for (int n = 0; n < 3; n++) begin
            step();
            checks++; if (STREAM_DONE !== 1'b0 || WIN_VALID !== 1'b0) begin failures++; $display("FAIL post_reset got=%b/%b exp=0/0", STREAM_DONE, WIN_VALID); end
        end
        load_img(0);
        START = 1'b1;
        step();
        START = 1'b0;
        checks++; if (WIN_VALID !== 1'b1 || X !== 5'd0 || Y !== 5'd0 || IMGIN !== exp_win(0, 0))
            begin failures++; $display("FAIL restart got=%b %0d,%0d %h", WIN_VALID, X, Y, IMGIN); end
    endtask

    task automatic test_back_to_back();
        logic [199:0] flat;
        flat = {25{8'h80}};
        for (int n = 0; n < 700 && STREAM_DONE !== 1'b1; n++) step();
        checks++; if (STREAM_DONE !== 1'b1) begin failures++; $display("FAIL b2b_done_wait got=%b exp=1", STREAM_DONE); end
        load_img(1);
        checks++; if (IMG_LOADED !== 1'b1) begin failures++; $display("FAIL b2b_loaded got=%b exp=1", IMG_LOADED); end
        START = 1'b1;
        step();
        START = 1'b0;
        for (int c = 0; c < 576; c++) begin
            checks++; if (WIN_VALID !== 1'b1 || X !== 5'(c/24) || Y !== 5'(c%24) || IMGIN !== flat)
                begin failures++; $display("FAIL b2b_win c=%0d got=%b %0d,%0d %h", c, WIN_VALID, X, Y, IMGIN); end
            step();
        end
        checks++; if (STREAM_DONE !== 1'b1 || WIN_VALID !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b/%b exp=1/0", STREAM_DONE, WIN_VALID); end
    endtask

    initial begin
        test_reset();
        test_start_ignored();
        test_ramp_stream();
        test_stall();
        test_midreset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
